// File: rtl/hazard_scoreboard_d_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Stage indices, forward-select encoding and the scoreboard entry record.
package pipe_hazard_pkg;

    localparam int TNEW_W = 2;
    localparam int STG_E  = 1;
    localparam int STG_M  = 2;
    localparam int STG_W  = 3;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic              vld;
        logic [4:0]        who;
        logic [TNEW_W-1:0] tnew;
    } sb_entry_t;

    function automatic logic [TNEW_W-1:0] sat_dec(
        input logic [TNEW_W-1:0] t
    );
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_d_md_busy_timer.sv
// HI/LO busy timer: loads the mult or div latency on issue,
// then counts down to zero; busy while non-zero.
module md_busy_timer #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (start) begin
            r_count <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign busy = (r_count != '0);

endmodule

// File: rtl/hazard_scoreboard_d.sv
// Decode-stage hazard unit: shift-register scoreboard of in-flight writes,
// Tnew/Tuse stall decision, D-stage forward selects and HI/LO busy stall.
module hazard_scoreboard_d
    import pipe_hazard_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int TNEW_W   = pipe_hazard_pkg::TNEW_W,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    localparam int SEL_W   = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              d_valid,
    input  logic [4:0]        d_who,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic [4:0]        d_rs,
    input  logic [4:0]        d_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic              d_md_use,
    input  logic              flush_d,
    output logic              stall_d,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic              md_busy
);

    sb_entry_t r_sb [1:NSTAGE];

    logic [NSTAGE:1]   w_rs_match;
    logic [NSTAGE:1]   w_rt_match;
    logic              w_rs_hit;
    logic              w_rt_hit;
    logic [SEL_W-1:0]  w_rs_k;
    logic [SEL_W-1:0]  w_rt_k;
    logic [TNEW_W-1:0] w_rs_tnew;
    logic [TNEW_W-1:0] w_rt_tnew;
    logic              w_rs_stall;
    logic              w_rt_stall;
    logic              w_md_stall;
    logic              w_accept;
    logic              w_md_start;

    assign w_accept   = d_valid & ~stall_d & ~flush_d;
    assign w_md_start = w_accept & d_md_start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                r_sb[k] <= '0;
            end
        end else begin
            r_sb[1].vld  <= w_accept & (d_who != 5'd0);
            r_sb[1].who  <= w_accept ? d_who : 5'd0;
            r_sb[1].tnew <= w_accept ? sat_dec(d_tnew) : '0;
            for (int k = 2; k <= NSTAGE; k++) begin
                r_sb[k].vld  <= r_sb[k-1].vld;
                r_sb[k].who  <= r_sb[k-1].who;
                r_sb[k].tnew <= sat_dec(r_sb[k-1].tnew);
            end
        end
    end

    genvar g;
    generate
        for (g = 1; g <= NSTAGE; g++) begin : g_match
            assign w_rs_match[g] = r_sb[g].vld & (r_sb[g].who == d_rs)
                                 & (d_rs != 5'd0);
            assign w_rt_match[g] = r_sb[g].vld & (r_sb[g].who == d_rt)
                                 & (d_rt != 5'd0);
        end
    endgenerate

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        w_rs_hit  = 1'b0;
        w_rs_k    = '0;
        w_rs_tnew = '0;
        w_rt_hit  = 1'b0;
        w_rt_k    = '0;
        w_rt_tnew = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (w_rs_match[k]) begin
                w_rs_hit  = 1'b1;
                w_rs_k    = SEL_W'(k);
                w_rs_tnew = r_sb[k].tnew;
            end
            if (w_rt_match[k]) begin
                w_rt_hit  = 1'b1;
                w_rt_k    = SEL_W'(k);
                w_rt_tnew = r_sb[k].tnew;
            end
        end
    end

    assign w_rs_stall = w_rs_hit & (w_rs_tnew > d_tuse_rs);
    assign w_rt_stall = w_rt_hit & (w_rt_tnew > d_tuse_rt);
    assign w_md_stall = (d_md_start | d_md_use) & md_busy;

    assign stall_d = d_valid & ~flush_d
                   & (w_rs_stall | w_rt_stall | w_md_stall);

    assign fwd_rs_sel = (w_rs_hit && w_rs_tnew == '0) ? w_rs_k
                                                       : SEL_W'(FWD_RF);
    assign fwd_rt_sel = (w_rt_hit && w_rt_tnew == '0) ? w_rt_k
                                                       : SEL_W'(FWD_RF);

    md_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_md_start),
        .is_div  (d_md_div),
        .busy    (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard_d.sv
// Bench for hazard_scoreboard_d: directed vector table, reset-mid-mult
// sequence, then random traffic against an age-based reference model.
module tb_hazard_scoreboard_d;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       d_valid;
    logic [4:0] d_who;
    logic [1:0] d_tnew;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic       d_md_start;
    logic       d_md_div;
    logic       d_md_use;
    logic       flush_d;
    logic       stall_d;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;
    logic       md_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_d dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_valid    (d_valid),
        .d_who      (d_who),
        .d_tnew     (d_tnew),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_md_use   (d_md_use),
        .flush_d    (flush_d),
        .stall_d    (stall_d),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy)
    );

    typedef struct {
        logic       v;
        logic [4:0] who;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] ur;
        logic [1:0] ut;
        logic       ms;
        logic       md;
        logic       mu;
        logic       fl;
        logic       e_st;
        logic [1:0] e_rs;
        logic [1:0] e_rt;
        logic       e_bz;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input int who, input int tn,
                       input int rs, input int rt, input int ur, input int ut,
                       input logic ms, input logic md, input logic mu,
                       input logic fl, input logic st, input int frs,
                       input int frt, input logic bz);
        vec_t x;
        x.v = v; x.who = 5'(who); x.tnew = 2'(tn);
        x.rs = 5'(rs); x.rt = 5'(rt); x.ur = 2'(ur); x.ut = 2'(ut);
        x.ms = ms; x.md = md; x.mu = mu; x.fl = fl;
        x.e_st = st; x.e_rs = 2'(frs); x.e_rt = 2'(frt); x.e_bz = bz;
        tbl.push_back(x);
    endtask

    task automatic drive(input logic v, input logic [4:0] who,
                         input logic [1:0] tn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [1:0] ur,
                         input logic [1:0] ut, input logic ms,
                         input logic md, input logic mu, input logic fl);
        d_valid = v; d_who = who; d_tnew = tn; d_rs = rs; d_rt = rt;
        d_tuse_rs = ur; d_tuse_rt = ut; d_md_start = ms; d_md_div = md;
        d_md_use = mu; flush_d = fl;
    endtask

    // Reference model: what was accepted 1..3 cycles ago, plus the cycle
    // at which HI/LO becomes free.
    bit hv[1:3];
    int hw[1:3];
    int ht[1:3];
    int cyc;
    int md_free_at;
    bit m_st;
    int m_rs;
    int m_rt;
    bit m_bz;

    task automatic model_reset();
        for (int k = 1; k <= 3; k++) begin
            hv[k] = 0; hw[k] = 0; ht[k] = 0;
        end
        cyc = 0;
        md_free_at = 0;
    endtask

    task automatic model_lookup(input int r, input int tuse,
                                output bit stl, output int sel);
        stl = 0;
        sel = 0;
        for (int k = 1; k <= 3; k++) begin
            if (r != 0 && hv[k] && hw[k] == r) begin
                int tn;
                tn = (ht[k] > k) ? ht[k] - k : 0;
                stl = (tn > tuse);
                sel = (tn == 0) ? k : 0;
                break;
            end
        end
    endtask

    task automatic model_eval();
        bit s_rs, s_rt;
        model_lookup(int'(d_rs), int'(d_tuse_rs), s_rs, m_rs);
        model_lookup(int'(d_rt), int'(d_tuse_rt), s_rt, m_rt);
        m_bz = (cyc < md_free_at);
        m_st = d_valid && !flush_d &&
               (s_rs || s_rt || ((d_md_start || d_md_use) && m_bz));
    endtask

    task automatic model_step();
        bit acc;
        acc = d_valid && !m_st && !flush_d;
        for (int k = 3; k >= 2; k--) begin
            hv[k] = hv[k-1]; hw[k] = hw[k-1]; ht[k] = ht[k-1];
        end
        hv[1] = acc && d_who != 0;
        hw[1] = int'(d_who);
        ht[1] = int'(d_tnew);
        if (acc && d_md_start)
            md_free_at = cyc + 1 + (d_md_div ? 10 : 5);
        cyc++;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // v who tn rs rt ur ut ms md mu fl | st frs frt bz
        add(1,  3, 2,  1,  2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1,  0, 0,  3,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1,  0, 0,  3,  0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        add(1,  5, 3, 29,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1,  6, 2,  4,  5, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1,  6, 2,  4,  5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1,  3, 2,  1,  2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1,  3, 2,  7,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1,  8, 2,  3,  3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1,  8, 2,  3,  3, 0, 1, 0, 0, 0, 0, 0, 2, 2, 0);
        add(1,  9, 2,  1,  2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 10, 2,  9,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1,  0, 0,  9, 10, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        add(1,  0, 2,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1,  0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1,  0, 0,  1,  2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            add(1, 11, 2, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 1);
        add(1, 11, 2,  0,  0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1,  0, 0,  1,  2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(1, 0, 0, 1, 2, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1);
        add(1,  0, 0,  1,  2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 12, 2,  1,  2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);

        @(negedge clk);
        #1;
        chk("rst_stall", stall_d, 0);
        chk("rst_fwd_rs", fwd_rs_sel, 0);
        chk("rst_fwd_rt", fwd_rt_sel, 0);
        chk("rst_busy", md_busy, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].who, tbl[i].tnew, tbl[i].rs, tbl[i].rt,
                  tbl[i].ur, tbl[i].ut, tbl[i].ms, tbl[i].md, tbl[i].mu,
                  tbl[i].fl);
            #1;
            chk($sformatf("vec%0d_stall", i), stall_d, tbl[i].e_st);
            chk($sformatf("vec%0d_fwd_rs", i), fwd_rs_sel, tbl[i].e_rs);
            chk($sformatf("vec%0d_fwd_rt", i), fwd_rt_sel, tbl[i].e_rt);
            chk($sformatf("vec%0d_busy", i), md_busy, tbl[i].e_bz);
            @(negedge clk);
        end

        // $12 is in E with Tnew 1 and a mult is running: reset must
        // clear both before any clock edge.
        drive(1, 0, 0, 12, 0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("pre_rst_stall", stall_d, 1);
        chk("pre_rst_busy", md_busy, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_stall", stall_d, 0);
        chk("midrst_busy", md_busy, 0);
        chk("midrst_fwd_rs", fwd_rs_sel, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) != 0,
                  5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            #1;
            model_eval();
            chk("rnd_stall", stall_d, m_st);
            chk("rnd_fwd_rs", fwd_rs_sel, m_rs);
            chk("rnd_fwd_rt", fwd_rt_sel, m_rt);
            chk("rnd_busy", md_busy, m_bz);
            model_step();
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
